// File: rtl/text_entry_ctrl_pkg.sv
// Shared constants, state encoding and byte classification for the text entry controller.
package text_entry_ctrl_pkg;

    localparam int DEF_COLS      = 20;
    localparam int DEF_TEXT_ROWS = 6;
    localparam int COL_W         = 6;
    localparam int ROW_W         = 4;

    localparam logic [7:0] ERASE_TOKEN = 8'hFF;
    localparam logic [7:0] BLANK_CODE  = 8'd129;   // what the RAM stores for ERASE_TOKEN

    localparam logic [7:0] ASCII_BS   = 8'h08;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_FF   = 8'h0C;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] PR_LO      = 8'h20;
    localparam logic [7:0] PR_HI      = 8'h7E;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_STATUS = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_FWD  = 1'b0,
        DIR_BACK = 1'b1
    } dir_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PR_LO) && (b <= PR_HI);
    endfunction

endpackage

// File: rtl/text_entry_ctrl_if.sv
// Byte-input handshake plus RAM write port and cursor view of the text entry controller.
interface text_entry_ctrl_if;
    import text_entry_ctrl_pkg::*;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic [COL_W-1:0] wr_col;
    logic [ROW_W-1:0] wr_row;
    logic             wr_status;
    logic [COL_W-1:0] cursor_col;
    logic [ROW_W-1:0] cursor_row;
    logic             busy;

    // Controller side: consumes bytes, drives the RAM port
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_data, wr_col, wr_row, wr_status,
               cursor_col, cursor_row, busy
    );

    // Byte source side (keyboard/UART front end)
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_data, wr_col, wr_row, wr_status,
               cursor_col, cursor_row, busy
    );

endinterface

// File: rtl/text_entry_ctrl_cursor_step.sv
// One step forward or backward over the row-major text area, wrapping at both ends.
module text_entry_ctrl_cursor_step
    import text_entry_ctrl_pkg::*;
#(
    parameter int N_COLS = DEF_COLS,
    parameter int N_ROWS = DEF_TEXT_ROWS
) (
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  dir_t             dir,
    output logic [COL_W-1:0] next_col,
    output logic [ROW_W-1:0] next_row
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

    // Neighbouring cell in the requested direction, wrapping column into row and row into 0/last
    always_comb begin
        next_col = col;
        next_row = row;
        if (dir == DIR_FWD) begin
            if (col == LAST_COL) begin
                next_col = '0;
                next_row = (row == LAST_ROW) ? '0 : row + ROW_W'(1);
            end else begin
                next_col = col + COL_W'(1);
            end
        end else begin
            if (col == '0) begin
                next_col = LAST_COL;
                next_row = (row == '0) ? LAST_ROW : row - ROW_W'(1);
            end else begin
                next_col = col - COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/text_entry_ctrl.sv
// Text entry controller: turns a byte stream into character RAM writes and tracks the cursor.
module text_entry_ctrl
    import text_entry_ctrl_pkg::*;
#(
    parameter int         COLS      = 20,
    parameter int         TEXT_ROWS = 6,
    parameter logic [7:0] ERASE     = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    text_entry_ctrl_if.slave bus
);

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(TEXT_ROWS - 1);
    localparam logic [ROW_W-1:0] STATUS_ROW = ROW_W'(TEXT_ROWS);

    // Stepper 0 moves the cursor, stepper 1 walks the clear sweep address
    localparam int N_STEP       = 2;
    localparam int STEP_CURSOR  = 0;
    localparam int STEP_SWEEP   = 1;

    state_t           state_reg;
    logic [COL_W-1:0] cursor_col_reg;
    logic [ROW_W-1:0] cursor_row_reg;
    logic             wr_en_reg;
    logic             wr_status_reg;
    logic [7:0]       wr_data_reg;
    logic [COL_W-1:0] wr_col_reg;
    logic [ROW_W-1:0] wr_row_reg;

    logic [COL_W-1:0] step_col_in  [N_STEP];
    logic [ROW_W-1:0] step_row_in  [N_STEP];
    dir_t             step_dir     [N_STEP];
    logic [COL_W-1:0] step_col_out [N_STEP];
    logic [ROW_W-1:0] step_row_out [N_STEP];

    logic at_origin;
    assign at_origin = (cursor_col_reg == '0) && (cursor_row_reg == '0);

    // Stepper inputs: enter reuses the forward step by pretending the cursor sits in the last column
    always_comb begin
        step_col_in[STEP_CURSOR] = (bus.rx_data == ASCII_CR) ? LAST_COL : cursor_col_reg;
        step_row_in[STEP_CURSOR] = cursor_row_reg;
        step_dir[STEP_CURSOR]    = (bus.rx_data == ASCII_BS) ? DIR_BACK : DIR_FWD;
        step_col_in[STEP_SWEEP]  = wr_col_reg;
        step_row_in[STEP_SWEEP]  = wr_row_reg;
        step_dir[STEP_SWEEP]     = DIR_FWD;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_STEP; gi++) begin : g_step
            text_entry_ctrl_cursor_step #(
                .N_COLS (COLS),
                .N_ROWS (TEXT_ROWS)
            ) u_step (
                .col      (step_col_in[gi]),
                .row      (step_row_in[gi]),
                .dir      (step_dir[gi]),
                .next_col (step_col_out[gi]),
                .next_row (step_row_out[gi])
            );
        end
    endgenerate

    // Control FSM; every RAM port output is registered here and held between writes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cursor_col_reg <= '0;
            cursor_row_reg <= '0;
            wr_en_reg      <= 1'b0;
            wr_status_reg  <= 1'b0;
            wr_data_reg    <= '0;
            wr_col_reg     <= '0;
            wr_row_reg     <= '0;
        end else begin
            wr_en_reg     <= 1'b0;
            wr_status_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        if (is_printable(bus.rx_data)) begin
                            wr_en_reg      <= 1'b1;
                            wr_data_reg    <= bus.rx_data;
                            wr_col_reg     <= cursor_col_reg;
                            wr_row_reg     <= cursor_row_reg;
                            cursor_col_reg <= step_col_out[STEP_CURSOR];
                            cursor_row_reg <= step_row_out[STEP_CURSOR];
                            state_reg      <= ST_WRITE;
                        end else if (bus.rx_data == ASCII_BS && !at_origin) begin
                            wr_en_reg      <= 1'b1;
                            wr_data_reg    <= ERASE;
                            wr_col_reg     <= step_col_out[STEP_CURSOR];
                            wr_row_reg     <= step_row_out[STEP_CURSOR];
                            cursor_col_reg <= step_col_out[STEP_CURSOR];
                            cursor_row_reg <= step_row_out[STEP_CURSOR];
                            state_reg      <= ST_WRITE;
                        end else if (bus.rx_data == ASCII_CR) begin
                            cursor_col_reg <= step_col_out[STEP_CURSOR];
                            cursor_row_reg <= step_row_out[STEP_CURSOR];
                            wr_en_reg      <= 1'b1;
                            wr_status_reg  <= 1'b1;
                            wr_data_reg    <= ASCII_ZERO + 8'(step_row_out[STEP_CURSOR]);
                            wr_col_reg     <= '0;
                            wr_row_reg     <= STATUS_ROW;
                            state_reg      <= ST_STATUS;
                        end else if (bus.rx_data == ASCII_FF) begin
                            wr_en_reg   <= 1'b1;
                            wr_data_reg <= ERASE;
                            wr_col_reg  <= '0;
                            wr_row_reg  <= '0;
                            state_reg   <= ST_CLEAR;
                        end
                    end
                end
                ST_WRITE: begin
                    wr_en_reg     <= 1'b1;
                    wr_status_reg <= 1'b1;
                    wr_data_reg   <= ASCII_ZERO + 8'(cursor_row_reg);
                    wr_col_reg    <= '0;
                    wr_row_reg    <= STATUS_ROW;
                    state_reg     <= ST_STATUS;
                end
                ST_STATUS: begin
                    state_reg <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (wr_col_reg == LAST_COL && wr_row_reg == LAST_ROW) begin
                        cursor_col_reg <= '0;
                        cursor_row_reg <= '0;
                        wr_en_reg      <= 1'b1;
                        wr_status_reg  <= 1'b1;
                        wr_data_reg    <= ASCII_ZERO;
                        wr_col_reg     <= '0;
                        wr_row_reg     <= STATUS_ROW;
                        state_reg      <= ST_STATUS;
                    end else begin
                        wr_en_reg   <= 1'b1;
                        wr_data_reg <= ERASE;
                        wr_col_reg  <= step_col_out[STEP_SWEEP];
                        wr_row_reg  <= step_row_out[STEP_SWEEP];
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.rx_ready   = (state_reg == ST_IDLE);
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.wr_en      = wr_en_reg;
    assign bus.wr_status  = wr_status_reg;
    assign bus.wr_data    = wr_data_reg;
    assign bus.wr_col     = wr_col_reg;
    assign bus.wr_row     = wr_row_reg;
    assign bus.cursor_col = cursor_col_reg;
    assign bus.cursor_row = cursor_row_reg;

endmodule

// File: tb/tb_text_entry_ctrl.sv
// Scoreboard bench for text_entry_ctrl: a cursor model queues every expected RAM write.
module tb_text_entry_ctrl;
    import text_entry_ctrl_pkg::*;

    localparam int M_COLS = 20;
    localparam int M_ROWS = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    text_entry_ctrl_if bus ();

    text_entry_ctrl #(
        .COLS      (M_COLS),
        .TEXT_ROWS (M_ROWS),
        .ERASE     (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [18:0] sb_q[$];
    int mcol = 0;
    int mrow = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] pk(input logic s, input logic [7:0] d, input int c, input int r);
        return {s, d, 6'(c), 4'(r)};
    endfunction

    // Every RAM write must match the head of the scoreboard
    always @(negedge clk) begin
        logic [18:0] got;
        logic [18:0] want;
        if (bus.wr_en === 1'b1) begin
            got = {bus.wr_status, bus.wr_data, bus.wr_col, bus.wr_row};
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                want = sb_q.pop_front();
                check("wr_cell", 32'(got), 32'(want));
            end
        end
    end

    function automatic logic [18:0] status_word(input int r);
        return pk(1'b1, 8'h30 + 8'(r), 0, M_ROWS);
    endfunction

    // Reference behaviour: queue writes, move model cursor, return edges until ready
    task automatic model(input logic [7:0] b, output int lat);
        lat = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            sb_q.push_back(pk(1'b0, b, mcol, mrow));
            if (mcol == M_COLS - 1) begin
                mcol = 0;
                mrow = (mrow + 1) % M_ROWS;
            end else begin
                mcol++;
            end
            sb_q.push_back(status_word(mrow));
            lat = 2;
        end else if (b == 8'h08) begin
            if (mcol != 0 || mrow != 0) begin
                if (mcol == 0) begin
                    mcol = M_COLS - 1;
                    mrow = (mrow + M_ROWS - 1) % M_ROWS;
                end else begin
                    mcol--;
                end
                sb_q.push_back(pk(1'b0, 8'hFF, mcol, mrow));
                sb_q.push_back(status_word(mrow));
                lat = 2;
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
            mrow = (mrow + 1) % M_ROWS;
            sb_q.push_back(status_word(mrow));
            lat = 1;
        end else if (b == 8'h0C) begin
            for (int r = 0; r < M_ROWS; r++)
                for (int c = 0; c < M_COLS; c++)
                    sb_q.push_back(pk(1'b0, 8'hFF, c, r));
            mcol = 0;
            mrow = 0;
            sb_q.push_back(status_word(0));
            lat = M_COLS * M_ROWS + 1;
        end
    endtask

    // One byte transaction: wait for ready, present for one edge, time the return of ready
    task automatic send(input logic [7:0] b);
        int lat_exp;
        int lat;
        int n;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.rx_ready), 32'd1);
        model(b, lat_exp);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        lat = 0;
        while (bus.rx_ready !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("ready_latency", 32'(lat), 32'(lat_exp));
        check("cursor_col", 32'(bus.cursor_col), 32'(mcol));
        check("cursor_row", 32'(bus.cursor_row), 32'(mrow));
        $display("byte 0x%02h: cursor (%0d,%0d) ready after %0d", b, bus.cursor_col, bus.cursor_row, lat);
    endtask

    initial begin
        int l1;
        int l2;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_status", 32'(bus.wr_status), 32'd0);
        check("rst_wr_addr", 32'({bus.wr_data, bus.wr_col, bus.wr_row}), 32'd0);
        check("rst_cursor", 32'({bus.cursor_col, bus.cursor_row}), 32'd0);
        $display("reset released");

        // 'A' at origin, then fill up to the last cell and wrap with 'Z'
        send(8'h41);
        for (int i = 0; i < 118; i++) send(8'h61 + 8'(i % 26));
        check("pre_wrap_col", 32'(bus.cursor_col), 32'd19);
        check("pre_wrap_row", 32'(bus.cursor_row), 32'd5);
        send(8'h5A);

        // Move to (0,2) and backspace across the row boundary
        for (int i = 0; i < 40; i++) send(8'h30 + 8'(i % 10));
        send(8'h08);

        // Clear screen, then backspace at origin must do nothing
        send(8'h0C);
        send(8'h08);
        check("bs_origin_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reach (7,3), then hold valid across a dropped byte and an enter
        repeat (3) send(8'h0D);
        for (int i = 0; i < 7; i++) send(8'h2A);
        check("pre_cr_col", 32'(bus.cursor_col), 32'd7);
        model(8'h07, l1);
        model(8'h0D, l2);
        bus.rx_data  = 8'h07;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        check("drop_no_write", 32'(bus.wr_en), 32'd0);
        bus.rx_data = 8'h0D;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("cr_status_n1", 32'({bus.wr_en, bus.wr_status}), 32'd3);
        check("cr_status_data", 32'(bus.wr_data), 32'h34);
        @(negedge clk);
        check("cr_ready", 32'(bus.rx_ready), 32'd1);
        check("cr_cursor", 32'({bus.cursor_col, bus.cursor_row}), 32'({6'd0, 4'd4}));
        $display("hold 0x07/0x0D: cursor (%0d,%0d)", bus.cursor_col, bus.cursor_row);

        // Reset in the middle of a clear sweep: only the first 50 cells get written
        for (int k = 0; k < 50; k++) sb_q.push_back(pk(1'b0, 8'hFF, k % M_COLS, k / M_COLS));
        bus.rx_data  = 8'h0C;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (49) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("sweep_rst_wr_en", 32'(bus.wr_en), 32'd0);
        reset = 1'b0;
        check("sweep_rst_ready", 32'(bus.rx_ready), 32'd1);
        check("sweep_rst_cursor", 32'({bus.cursor_col, bus.cursor_row}), 32'd0);
        check("sweep_rst_sb_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check("sweep_rst_idle_wr_en", 32'(bus.wr_en), 32'd0);
        mcol = 0;
        mrow = 0;
        $display("reset during clear sweep");

        send(8'h42);
        repeat (2) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
